// File: rtl/jtgng_obj_pkg.sv
// Shared definitions for the object DMA: FSM state encoding and default sizes.
package jtgng_obj_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_COPY = 2'd2,
    ST_REL  = 2'd3
  } objdma_state_t;

  localparam int unsigned OBJMAX_DEF = 32'h180;
  localparam int unsigned AW_DEF     = 9;

endpackage

// File: rtl/jtgng_objdma.sv
// Copies OBJMAX sprite bytes from CPU RAM into object RAM under a bus request/grant handshake.
// Optional macro JTGNG_OBJDMA_VBLANK_EN holds a request until vertical blank (LVBL low).
module jtgng_objdma
  import jtgng_obj_pkg::*;
#(
  parameter int unsigned OBJMAX = OBJMAX_DEF,
  parameter int unsigned AW     = AW_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cen6,
  input  logic          LVBL,
  input  logic          OKOUT,
  input  logic          bus_ack,
  output logic          bus_req,
  output logic [AW-1:0] dma_addr,
  input  logic [7:0]    dma_din,
  output logic [AW-1:0] obj_addr,
  output logic [7:0]    obj_data,
  output logic          obj_we,
  output logic          busy
);

  localparam logic [AW:0] LAST_ADDR = (AW+1)'(OBJMAX - 1);

  objdma_state_t st;
  logic          okout_l;
  logic          pending;
  logic          primed;   // dma_din currently holds data for dma_addr
  logic          last;     // final byte written, release on next tick
  logic [AW:0]   cnt;
  logic          ok_edge;
  logic          vb_ok;

  assign ok_edge  = OKOUT & ~okout_l;
  assign dma_addr = cnt[AW-1:0];

`ifdef JTGNG_OBJDMA_VBLANK_EN
  assign vb_ok = ~LVBL;
`else
  logic unused_lvbl;
  assign vb_ok       = 1'b1;
  assign unused_lvbl = LVBL;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st       <= ST_IDLE;
      okout_l  <= 1'b0;
      pending  <= 1'b0;
      primed   <= 1'b0;
      last     <= 1'b0;
      cnt      <= '0;
      bus_req  <= 1'b0;
      busy     <= 1'b0;
      obj_we   <= 1'b0;
      obj_addr <= '0;
      obj_data <= 8'd0;
    end else if (cen6) begin
      okout_l <= OKOUT;
      obj_we  <= 1'b0;
      // A single request can be queued while a transfer is in progress
      if (ok_edge && st != ST_IDLE) pending <= 1'b1;
      case (st)
        ST_IDLE: begin
          if ((ok_edge || pending) && vb_ok) begin
            st      <= ST_REQ;
            bus_req <= 1'b1;
            busy    <= 1'b1;
            pending <= 1'b0;
          end else if (ok_edge) begin
            pending <= 1'b1;
          end
        end
        ST_REQ: begin
          if (bus_ack) begin
            st     <= ST_COPY;
            cnt    <= '0;
            primed <= 1'b1;
            last   <= 1'b0;
          end
        end
        ST_COPY: begin
          if (last) begin
            st      <= ST_REL;
            bus_req <= 1'b0;
            last    <= 1'b0;
            primed  <= 1'b0;
          end else if (!bus_ack) begin
            // Read in flight is lost; the held address is re-read on grant
            primed <= 1'b0;
          end else if (!primed) begin
            primed <= 1'b1;
          end else begin
            obj_addr <= dma_addr;
            obj_data <= dma_din;
            obj_we   <= 1'b1;
            if (cnt == LAST_ADDR) last <= 1'b1;
            else                  cnt  <= cnt + (AW+1)'(1);
          end
        end
        ST_REL: begin
          if (!bus_ack) begin
            st   <= ST_IDLE;
            busy <= 1'b0;
          end
        end
        default: st <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_jtgng_objdma.sv
// Directed bench for jtgng_objdma with a CPU bus arbiter and a source RAM model.
module tb_jtgng_objdma;

  localparam int AW     = 9;
  localparam int OBJMAX = 'h180;
`ifdef JTGNG_OBJDMA_VBLANK_EN
  localparam logic LVBL_DFLT = 1'b0;
`else
  localparam logic LVBL_DFLT = 1'b1;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          cen6 = 1'b0;
  logic          LVBL = LVBL_DFLT;
  logic          OKOUT = 1'b0;
  logic          bus_ack = 1'b0;
  logic          bus_req;
  logic [AW-1:0] dma_addr;
  logic [7:0]    dma_din = 8'd0;
  logic [AW-1:0] obj_addr;
  logic [7:0]    obj_data;
  logic          obj_we;
  logic          busy;

  logic [1:0]    div = 2'd0;
  logic [7:0]    src [0:511];

  int n_total = 0;
  int n_pass  = 0;

  // results of the last run_bus call
  int wr_total, order_err, data_err, nack_wr, a40_cnt, req_rises, rise_ack_hi;
  int req_tick, ack_tick, ack_to_drop, max_addr, we_no_req, rel_early, timeout;

  jtgng_objdma dut (
    .clk      (clk),
    .rst      (rst),
    .cen6     (cen6),
    .LVBL     (LVBL),
    .OKOUT    (OKOUT),
    .bus_ack  (bus_ack),
    .bus_req  (bus_req),
    .dma_addr (dma_addr),
    .dma_din  (dma_din),
    .obj_addr (obj_addr),
    .obj_data (obj_data),
    .obj_we   (obj_we),
    .busy     (busy)
  );

  always #10 clk = ~clk;

  always @(negedge clk) begin
    div  = div + 2'd1;
    cen6 = (div == 2'd0);
  end

  // CPU-side RAM: synchronous read, settles within one cen6 period
  always @(posedge clk) dma_din <= src[dma_addr];

  task automatic wait_tick();
    do @(posedge clk); while (!cen6);
    #1;
  endtask

  task automatic run_bus(input int lvbl_fall, input int pause_at, input int pulse_a,
                         input int pulse_b, input int abort_at);
    int t, quiet, req_age, rel_age, pause_left;
    bit paused, prev_ack, prev_req;
    t = 0; quiet = 0; req_age = 0; rel_age = 0; pause_left = 0; paused = 0;
    wr_total = 0; order_err = 0; data_err = 0; nack_wr = 0; a40_cnt = 0;
    req_rises = 0; rise_ack_hi = 0; req_tick = -1; ack_tick = -1; ack_to_drop = -1;
    max_addr = 0; we_no_req = 0; rel_early = 0; timeout = 0;
    prev_req = bus_req;
    OKOUT = 1'b1;
    forever begin
      prev_ack = bus_ack;
      wait_tick();
      t++;
      if (t == 1) OKOUT = 1'b0;
      if (t == pulse_a || t == pulse_b) OKOUT = 1'b1;
      if (t == pulse_a + 1 || t == pulse_b + 1) OKOUT = 1'b0;
      if (t == lvbl_fall) LVBL = 1'b0;
      if (obj_we) begin
        if (!prev_ack) nack_wr++;
        if (!bus_req) we_no_req++;
        if (obj_addr != AW'(wr_total % OBJMAX)) order_err++;
        if (obj_data != src[obj_addr]) data_err++;
        if (obj_addr == AW'('h40)) a40_cnt++;
        wr_total++;
      end
      if (int'(dma_addr) > max_addr) max_addr = int'(dma_addr);
      if (bus_req && !prev_req) begin
        req_rises++;
        if (prev_ack) rise_ack_hi++;
        if (req_tick < 0) req_tick = t;
      end
      if (!bus_req && prev_req && ack_tick >= 0 && ack_to_drop < 0) ack_to_drop = t - ack_tick;
      prev_req = bus_req;
      if (!busy && bus_ack) rel_early++;
      if (abort_at >= 0 && int'(dma_addr) == abort_at && bus_ack) return;
      // CPU arbiter: grant after a short delay, optional pause, late release
      if (bus_req) begin
        rel_age = 0;
        if (pause_left > 0) begin
          pause_left--;
          if (pause_left == 0) bus_ack = 1'b1;
        end else if (!bus_ack) begin
          req_age++;
          if (req_age >= 3) begin
            bus_ack = 1'b1;
            if (ack_tick < 0) ack_tick = t;
          end
        end else if (pause_at >= 0 && !paused && int'(dma_addr) == pause_at) begin
          bus_ack = 1'b0; paused = 1; pause_left = 5;
        end
      end else begin
        req_age = 0;
        if (bus_ack) begin
          rel_age++;
          if (rel_age >= 3) bus_ack = 1'b0;
        end
      end
      if (!busy && req_tick >= 0) quiet++; else quiet = 0;
      if (quiet >= 4) return;
      if (t > 3000) begin timeout = 1; return; end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    n_total++; if (bus_req !== 1'b0) $display("FAIL rst_bus_req got %b exp 0", bus_req); else n_pass++;
    n_total++; if (busy !== 1'b0) $display("FAIL rst_busy got %b exp 0", busy); else n_pass++;
    n_total++; if (obj_we !== 1'b0) $display("FAIL rst_obj_we got %b exp 0", obj_we); else n_pass++;
    n_total++; if (dma_addr !== 9'h000) $display("FAIL rst_dma_addr got %h exp 000", dma_addr); else n_pass++;
    n_total++; if (obj_addr !== 9'h000) $display("FAIL rst_obj_addr got %h exp 000", obj_addr); else n_pass++;
    n_total++; if (obj_data !== 8'h00) $display("FAIL rst_obj_data got %h exp 00", obj_data); else n_pass++;
    rst = 1'b0;
    repeat (3) wait_tick();
    n_total++; if (bus_req !== 1'b0) $display("FAIL idle_bus_req got %b exp 0", bus_req); else n_pass++;
  endtask

  task automatic test_single_dma();
    run_bus(-1, -1, -1, -1, -1);
    n_total++; if (timeout !== 0) $display("FAIL single_timeout got %0d exp 0", timeout); else n_pass++;
    n_total++; if (req_tick !== 1) $display("FAIL single_req_tick got %0d exp 1", req_tick); else n_pass++;
    n_total++; if (wr_total !== 384) $display("FAIL single_writes got %0d exp 384", wr_total); else n_pass++;
    n_total++; if (order_err !== 0) $display("FAIL single_order got %0d exp 0", order_err); else n_pass++;
    n_total++; if (data_err !== 0) $display("FAIL single_data got %0d exp 0", data_err); else n_pass++;
    n_total++; if (max_addr !== 'h17F) $display("FAIL single_max_addr got %0h exp 17f", max_addr); else n_pass++;
    n_total++; if (ack_to_drop !== 386) $display("FAIL single_copy_len got %0d exp 386", ack_to_drop); else n_pass++;
    n_total++; if (we_no_req !== 0) $display("FAIL single_we_no_req got %0d exp 0", we_no_req); else n_pass++;
    n_total++; if (rel_early !== 0) $display("FAIL single_rel_early got %0d exp 0", rel_early); else n_pass++;
    n_total++; if (busy !== 1'b0 || bus_req !== 1'b0) $display("FAIL single_end got busy=%b req=%b exp 0 0", busy, bus_req); else n_pass++;
  endtask

  task automatic test_pause();
    run_bus(-1, 'h40, -1, -1, -1);
    n_total++; if (timeout !== 0) $display("FAIL pause_timeout got %0d exp 0", timeout); else n_pass++;
    n_total++; if (nack_wr !== 0) $display("FAIL pause_we_during_pause got %0d exp 0", nack_wr); else n_pass++;
    n_total++; if (a40_cnt !== 1) $display("FAIL pause_addr40_writes got %0d exp 1", a40_cnt); else n_pass++;
    n_total++; if (wr_total !== 384) $display("FAIL pause_writes got %0d exp 384", wr_total); else n_pass++;
    n_total++; if (order_err !== 0) $display("FAIL pause_order got %0d exp 0", order_err); else n_pass++;
    n_total++; if (data_err !== 0) $display("FAIL pause_data got %0d exp 0", data_err); else n_pass++;
    n_total++; if (ack_to_drop !== 392) $display("FAIL pause_copy_len got %0d exp 392", ack_to_drop); else n_pass++;
  endtask

  task automatic test_back_to_back();
    run_bus(-1, -1, 20, 40, -1);
    n_total++; if (timeout !== 0) $display("FAIL b2b_timeout got %0d exp 0", timeout); else n_pass++;
    n_total++; if (req_rises !== 2) $display("FAIL b2b_dma_count got %0d exp 2", req_rises); else n_pass++;
    n_total++; if (wr_total !== 768) $display("FAIL b2b_writes got %0d exp 768", wr_total); else n_pass++;
    n_total++; if (order_err !== 0) $display("FAIL b2b_order got %0d exp 0", order_err); else n_pass++;
    n_total++; if (rise_ack_hi !== 0) $display("FAIL b2b_req_before_release got %0d exp 0", rise_ack_hi); else n_pass++;
    n_total++; if (rel_early !== 0) $display("FAIL b2b_rel_early got %0d exp 0", rel_early); else n_pass++;
  endtask

  task automatic test_reset_abort();
    int wr_after, req_after;
    run_bus(-1, -1, -1, -1, 'h100);
    n_total++; if (wr_total !== 256) $display("FAIL abort_writes_before got %0d exp 256", wr_total); else n_pass++;
    rst = 1'b1;
    #1;
    n_total++; if (bus_req !== 1'b0) $display("FAIL abort_bus_req got %b exp 0", bus_req); else n_pass++;
    n_total++; if (busy !== 1'b0) $display("FAIL abort_busy got %b exp 0", busy); else n_pass++;
    n_total++; if (obj_we !== 1'b0) $display("FAIL abort_obj_we got %b exp 0", obj_we); else n_pass++;
    n_total++; if (dma_addr !== 9'h000) $display("FAIL abort_dma_addr got %h exp 000", dma_addr); else n_pass++;
    n_total++; if (obj_addr !== 9'h000 || obj_data !== 8'h00) $display("FAIL abort_obj got %h/%h exp 000/00", obj_addr, obj_data); else n_pass++;
    OKOUT = 1'b0;
    bus_ack = 1'b0;
    repeat (5) @(posedge clk);
    #1 rst = 1'b0;
    wr_after = 0; req_after = 0;
    repeat (40) begin
      wait_tick();
      if (obj_we) wr_after++;
      if (bus_req) req_after++;
    end
    n_total++; if (wr_after !== 0) $display("FAIL abort_writes_after got %0d exp 0", wr_after); else n_pass++;
    n_total++; if (req_after !== 0) $display("FAIL abort_resume got %0d exp 0", req_after); else n_pass++;
  endtask

  task automatic test_vblank();
    LVBL = 1'b1;
    run_bus(10, -1, -1, -1, -1);
    n_total++; if (timeout !== 0) $display("FAIL vblank_timeout got %0d exp 0", timeout); else n_pass++;
`ifdef JTGNG_OBJDMA_VBLANK_EN
    n_total++; if (req_tick !== 11) $display("FAIL vblank_req_tick got %0d exp 11", req_tick); else n_pass++;
`else
    n_total++; if (req_tick !== 1) $display("FAIL vblank_req_tick got %0d exp 1", req_tick); else n_pass++;
`endif
    n_total++; if (wr_total !== 384) $display("FAIL vblank_writes got %0d exp 384", wr_total); else n_pass++;
    n_total++; if (data_err !== 0) $display("FAIL vblank_data got %0d exp 0", data_err); else n_pass++;
    LVBL = LVBL_DFLT;
  endtask

  initial begin
    for (int i = 0; i < 512; i++) src[i] = 8'(i * 37 + 5);
    test_reset();
    test_single_dma();
    test_pause();
    test_back_to_back();
    test_reset_abort();
    test_vblank();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/jtgng_objdma.md
JTGNG_OBJDMA -- requirements
Module: jtgng_objdma

Interface
REQ-001 Parameter OBJMAX, default 10'h180, number of sprite bytes copied per DMA.
REQ-002 Parameter AW, default 9, address width of source and destination.
REQ-003 clk  input  1  system clock, 24 MHz.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 cen6  input  1  6 MHz clock enable; all state advances only on cen6.
REQ-006 LVBL  input  1  vertical blank, active low.
REQ-007 OKOUT  input  1  CPU DMA request strobe, level; a rising edge is a request.
REQ-008 bus_ack  input  1  CPU bus grant, active high.
REQ-009 bus_req  output  1  CPU bus request, active high.
REQ-010 dma_addr  output  AW  read address into CPU-side sprite RAM.
REQ-011 dma_din  input  8  CPU-side RAM data, valid one cen6 after dma_addr.
REQ-012 obj_addr  output  AW  write address into object RAM scanned by the sprite buffer.
REQ-013 obj_data  output  8  write data into object RAM.
REQ-014 obj_we  output  1  object RAM write enable, qualified by cen6.
REQ-015 busy  output  1  high from request acceptance until bus release completes.

Function
REQ-016 FSM states: IDLE, REQ, COPY, REL; transitions evaluated only on cen6.
REQ-017 IDLE->REQ on a pending request (OKOUT rising edge, sampled on cen6); bus_req goes high in the same cen6 tick.
REQ-018 REQ->COPY on the first cen6 with bus_ack=1; dma_addr=0 on COPY entry.
REQ-019 In COPY, dma_addr increments by 1 per cen6 while bus_ack=1; obj_addr=dma_addr delayed one cen6; obj_data=dma_din; obj_we=1 for each delayed valid address.
REQ-020 Exactly OBJMAX writes per DMA, addresses 0..OBJMAX-1 in order; COPY lasts OBJMAX+1 cen6 ticks without pauses.
REQ-021 bus_ack falling in COPY: pause -- hold dma_addr, obj_we=0, discard in-flight read; on bus_ack return, re-issue the held address; no byte skipped or duplicated.
REQ-022 COPY->REL after last write; bus_req=0 in REL; REL->IDLE when bus_ack=0.
REQ-023 OKOUT rising edge while busy sets one pending flag (further edges ignored); pending request starts from IDLE the tick after REL completes.
REQ-024 dma_addr never exceeds OBJMAX-1; counter width AW+1 internally to avoid wrap at OBJMAX=2^AW.
REQ-025 obj_we=0 in IDLE, REQ and REL.

Reset
REQ-026 On rst: state=IDLE, bus_req=0, obj_we=0, busy=0, dma_addr=0, obj_addr=0, obj_data=0, pending=0, edge-detect register=0.
REQ-027 Reset asserted mid-COPY aborts immediately; no resume after release; bus_req drops asynchronously.

Configuration
REQ-028 Macro JTGNG_OBJDMA_VBLANK_EN: when defined, IDLE->REQ additionally requires LVBL=0 (request held pending until vblank); when undefined, request proceeds regardless of LVBL.

Structure
REQ-029 FSM state encodings and OBJMAX default in shared package jtgng_obj_pkg; no sub-module -- single flat module, address counter inline.

Verification
REQ-030 OKOUT edge, bus_ack 2 ticks after bus_req -> 384 writes, obj_addr 0..0x17F, obj_data matches source pattern, bus_req drops, busy low.
REQ-031 bus_ack low for 5 ticks at dma_addr=0x40 -> no obj_we during pause, 0x40 written once, total writes still 384.
REQ-032 Two OKOUT edges during busy -> exactly two DMAs back-to-back, second starts after bus_ack=0.
REQ-033 rst pulse at dma_addr=0x100 -> bus_req=0 immediately, outputs at reset values, no further writes.
REQ-034 With JTGNG_OBJDMA_VBLANK_EN, OKOUT edge while LVBL=1 -> bus_req stays 0 until LVBL falls, then copy completes; without macro bus_req rises next cen6.
